wb_port_arbiter: RTL

- Shares the single register-file write port between two sources: the in-order pipeline WB stage (the output of the writeback source mux) and a long-latency unit such as mul/div.
- Long-unit results are queued in a small FIFO and drained into idle port cycles.
- A starvation counter forces a drain slot by stalling WB.
- A combinational scoreboard reports pending destinations to the hazard unit.

---
 rtl/wb_port_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage and a queued long-latency unit.
// Queued results fill idle port cycles, and a starvation counter can force a drain by stalling WB.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              pipe_we,
    input  logic [REG_AW-1:0] pipe_rd,
    input  logic [XLEN-1:0]   pipe_data,
    input  logic              lu_valid,
    input  logic [REG_AW-1:0] lu_rd,
    input  logic [XLEN-1:0]   lu_data,
    output logic              lu_ready,
    output logic              pipe_stall,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    input  logic [REG_AW-1:0] chk_rs1,
    input  logic [REG_AW-1:0] chk_rs2,
    input  logic [REG_AW-1:0] chk_rd,
    output logic              chk_hit,
    output logic              fifo_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [REG_AW-1:0] mem_rd   [DEPTH];
    logic [XLEN-1:0]   mem_data [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [SW-1:0]     starve_cnt;

    logic pipe_req;
    logic fifo_nonempty;
    logic force_drain;
    logic fifo_gnt;
    logic pipe_gnt;
    logic push;
    logic pop;

    assign pipe_req      = pipe_we && (pipe_rd != '0);
    assign fifo_nonempty = (count != '0);
    assign force_drain   = (starve_cnt == SW'(STARVE_LIMIT)) && fifo_nonempty;
    assign pipe_stall    = rstn && force_drain && pipe_req;
    assign lu_ready      = rstn && (count < CW'(DEPTH));
    assign fifo_empty    = !fifo_nonempty;
    // x0 results are acknowledged to the long unit but never occupy a slot.
    assign push          = lu_valid && lu_ready && (lu_rd != '0);
    assign pop           = fifo_gnt;

    always_comb begin
        fifo_gnt = 1'b0;
        pipe_gnt = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (rstn) begin
            if (force_drain || (!pipe_req && fifo_nonempty)) begin
                fifo_gnt = 1'b1;
            end else if (pipe_req) begin
                pipe_gnt = 1'b1;
            end
        end
        if (fifo_gnt) begin
            rf_we    = 1'b1;
            rf_waddr = mem_rd[rd_ptr];
            rf_wdata = mem_data[rd_ptr];
        end else if (pipe_gnt) begin
            rf_we    = 1'b1;
            rf_waddr = pipe_rd;
            rf_wdata = pipe_data;
        end
    end

    // Slot i is live when its distance from the head is below the occupancy count.
    always_comb begin
        logic [PW-1:0] offset;
        chk_hit = 1'b0;
        offset  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - rd_ptr;
            if (CW'(offset) < count) begin
                if ((chk_rs1 != '0) && (mem_rd[i] == chk_rs1)) chk_hit = 1'b1;
                if ((chk_rs2 != '0) && (mem_rd[i] == chk_rs2)) chk_hit = 1'b1;
                if ((chk_rd  != '0) && (mem_rd[i] == chk_rd))  chk_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= lu_rd;
            mem_data[wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (!fifo_nonempty || fifo_gnt) begin
                starve_cnt <= '0;
            end else if (pipe_gnt && (starve_cnt != SW'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule
